// File: rtl/fma_write_buffer_if.sv
// Bundle between the FMA result port, the line buffer and the memory buffer-input port.
// The buffer drives the slave side; the FMA array and memory together form the master side.
interface fma_write_buffer_if #(
  parameter int FMA_COUNT  = 2,
  parameter int WORD_WIDTH = 16,
  parameter int SLOTS      = 3,
  parameter int LINE_WIDTH = SLOTS * FMA_COUNT * WORD_WIDTH
);
  logic [FMA_COUNT*WORD_WIDTH-1:0] fma_c_in;
  logic                            fma_valid_in;
  logic                            flush_in;
  logic                            line_ack_in;
  logic [LINE_WIDTH-1:0]           line_out;
  logic                            line_valid_out;
  logic [1:0]                      fill_count_out;
  logic                            overflow_out;
  logic                            idle_out;

  modport master (
    output fma_c_in, fma_valid_in, flush_in, line_ack_in,
    input  line_out, line_valid_out, fill_count_out, overflow_out, idle_out
  );

  modport slave (
    input  fma_c_in, fma_valid_in, flush_in, line_ack_in,
    output line_out, line_valid_out, fill_count_out, overflow_out, idle_out
  );
endinterface

// File: rtl/fma_write_buffer.sv
// Packs SLOTS consecutive FMA result sets into one memory line, double-buffered:
// a fill register accumulates while the out register holds the presented line.
module fma_write_buffer #(
  parameter int FMA_COUNT  = 2,
  parameter int WORD_WIDTH = 16,
  parameter int SLOTS      = 3,
  parameter int LINE_WIDTH = SLOTS * FMA_COUNT * WORD_WIDTH
) (
  input logic              clk_in,
  input logic              rst_in,
  fma_write_buffer_if.slave bus
);
  localparam int         SET_W   = FMA_COUNT * WORD_WIDTH;
  localparam logic [1:0] SLOTS_C = 2'(SLOTS);

  logic [LINE_WIDTH-1:0] fill_q, fill_d, out_q, out_d, fill_acc;
  logic [1:0]            cnt_q, cnt_d, cnt_acc;
  logic                  pend_q, pend_d;
  logic                  vld_q, vld_d;
  logic                  ovf_q, ovf_d;
  logic                  idle_q, idle_d;
  logic                  out_free, close;

  always_comb begin
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    out_d    = out_q;
    vld_d    = vld_q;
    ovf_d    = ovf_q;
    fill_acc = fill_q;
    cnt_acc  = cnt_q;
    close    = 1'b0;
    out_free = !vld_q || bus.line_ack_in;

    if (pend_q) begin
      // A pending fill blocks accepts; a set arriving on promotion seeds the fresh fill.
      if (out_free) begin
        out_d  = fill_q;
        vld_d  = 1'b1;
        fill_d = '0;
        cnt_d  = 2'd0;
        pend_d = 1'b0;
        if (bus.fma_valid_in) begin
          fill_d[SET_W-1:0] = bus.fma_c_in;
          cnt_d             = 2'd1;
        end
      end else if (bus.fma_valid_in) begin
        ovf_d = 1'b1;
      end
    end else begin
      if (bus.fma_valid_in) begin
        for (int k = 0; k < SLOTS; k++) begin
          if (cnt_q == 2'(k)) fill_acc[k*SET_W +: SET_W] = bus.fma_c_in;
        end
        cnt_acc = cnt_q + 2'd1;
      end
      close = (cnt_acc == SLOTS_C) || (bus.flush_in && cnt_acc != 2'd0);
      if (close && out_free) begin
        out_d  = fill_acc;
        vld_d  = 1'b1;
        fill_d = '0;
        cnt_d  = 2'd0;
        pend_d = 1'b0;
      end else begin
        fill_d = fill_acc;
        cnt_d  = cnt_acc;
        pend_d = close;
        if (bus.line_ack_in) vld_d = 1'b0;
      end
    end

    idle_d = (cnt_d == 2'd0) && !pend_d && !vld_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fill_q <= '0;
      cnt_q  <= 2'd0;
      pend_q <= 1'b0;
      out_q  <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
      idle_q <= 1'b1;
    end else begin
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      out_q  <= out_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
      idle_q <= idle_d;
    end
  end

  assign bus.line_out       = out_q;
  assign bus.line_valid_out = vld_q;
  assign bus.fill_count_out = cnt_q;
  assign bus.overflow_out   = ovf_q;
  assign bus.idle_out       = idle_q;
endmodule
